mod_enc_round_ctrl: RTL

Sequencer for the AES-256 encryption round datapath: SubBytes, then the ShiftRows shifter, then MixColumns, then AddRoundKey.
- Owns the 128-bit state register.
- Drives the round-key index toward key expansion.
- Controls the round datapath's MixColumns bypass and initial-round AddRoundKey-only mode.
- Wraps the whole encryption in valid/ready handshakes on input and output.
- One block in flight at a time.

---
 rtl/mod_enc_round_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/mod_enc_round_ctrl.sv
// Round sequencer for an AES-256 encryption datapath: holds the block state,
// steps the round-key index and selects the datapath mode for each round.
module mod_enc_round_ctrl #(
   parameter int N  = 16,
   parameter int NR = 14
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N-1:0][7:0]  in_data,
   output logic [3:0]         key_idx,
   input  logic               key_rdy,
   output logic               ark_only,
   output logic               mix_bypass,
   output logic [N-1:0][7:0]  round_in,
   input  logic [N-1:0][7:0]  round_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N-1:0][7:0]  out_data,
   output logic [3:0]         round,
   output logic               busy
);

   typedef enum logic [2:0] {IDLE, INIT, ROUND, LAST, DONE} state_t;

   localparam logic [3:0] LAST_ROUND = 4'(NR);
   localparam logic [3:0] PRE_LAST   = 4'(NR - 1);

   state_t              fsm;
   logic [N-1:0][7:0]   blk;

   assign round_in = blk;
   assign out_data = blk;

   // Mode outputs are set on the edge that enters a state, so key_idx,
   // ark_only and mix_bypass are already valid in the state's first cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm        <= IDLE;
         blk        <= '0;
         round      <= '0;
         key_idx    <= '0;
         ark_only   <= 1'b0;
         mix_bypass <= 1'b0;
         out_valid  <= 1'b0;
         in_ready   <= 1'b1;
         busy       <= 1'b0;
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid) begin
                  blk      <= in_data;
                  round    <= '0;
                  key_idx  <= '0;
                  ark_only <= 1'b1;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  fsm      <= INIT;
               end
            end
            INIT: begin
               if (key_rdy) begin
                  blk      <= round_out;
                  round    <= 4'd1;
                  key_idx  <= 4'd1;
                  ark_only <= 1'b0;
                  fsm      <= ROUND;
               end
            end
            ROUND: begin
               if (key_rdy) begin
                  blk <= round_out;
                  if (round == PRE_LAST) begin
                     round      <= LAST_ROUND;
                     key_idx    <= LAST_ROUND;
                     mix_bypass <= 1'b1;
                     fsm        <= LAST;
                  end else begin
                     round   <= round + 4'd1;
                     key_idx <= round + 4'd1;
                  end
               end
            end
            LAST: begin
               if (key_rdy) begin
                  blk        <= round_out;
                  mix_bypass <= 1'b0;
                  out_valid  <= 1'b1;
                  fsm        <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  round     <= '0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  fsm       <= IDLE;
               end
            end
            default: begin
               fsm       <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
